// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if: RAM-port and output-stream signals of the FIFO read controller
interface fifo_stream_reader_if #(parameter int SIZE = 256, parameter int DATA_WIDTH = 8);
  localparam int AW = $clog2(SIZE);
  localparam int CW = $clog2(SIZE + 1);
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic                  rd_en;
  logic [AW-1:0]         rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  dout_ready;
  logic [CW-1:0]         count;
  logic                  full;
  logic                  empty;
  logic                  overflow;
  modport master (
    output wr_en, rd_data, dout_ready,
    input  wr_addr, rd_en, rd_addr, dout, dout_valid, count, full, empty, overflow
  );
  modport slave (
    input  wr_en, rd_data, dout_ready,
    output wr_addr, rd_en, rd_addr, dout, dout_valid, count, full, empty, overflow
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: read controller for a 1-cycle-latency block RAM FIFO with a 2-entry skid buffer
module fifo_stream_reader #(
  parameter int SIZE       = 256,
  parameter int DATA_WIDTH = 8
) (
  input logic clk,
  input logic rst,
  fifo_stream_reader_if.slave bus
);
  localparam int AW = $clog2(SIZE);
  localparam int CW = $clog2(SIZE + 1);
  localparam logic [AW-1:0] LAST = AW'(SIZE - 1);
  logic [CW-1:0]         ram_cnt;
  logic                  inflight;
  logic [1:0]            buf_cnt;
  logic [DATA_WIDTH-1:0] b0, b1;
  logic                  pop, wr_acc;
  assign pop           = (|buf_cnt) & bus.dout_ready;
  assign wr_acc        = bus.wr_en & ~bus.full;
  assign bus.full      = bus.count == CW'(SIZE);
  assign bus.empty     = bus.count == '0;
  assign bus.dout      = b0;
  assign bus.dout_valid = |buf_cnt;
  // ram_cnt is registered, so a word becomes readable only after its write edge
  assign bus.rd_en = (ram_cnt != '0) & ({1'b0, buf_cnt} + 3'(inflight) < 3'd2 + 3'(pop));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.wr_addr  <= '0;
      bus.rd_addr  <= '0;
      bus.count    <= '0;
      bus.overflow <= 1'b0;
      ram_cnt      <= '0;
      inflight     <= 1'b0;
      buf_cnt      <= '0;
      b0           <= '0;
      b1           <= '0;
    end else begin
      if (wr_acc) bus.wr_addr <= bus.wr_addr == LAST ? '0 : bus.wr_addr + 1'b1;
      if (bus.rd_en) bus.rd_addr <= bus.rd_addr == LAST ? '0 : bus.rd_addr + 1'b1;
      bus.count    <= bus.count + CW'(wr_acc) - CW'(pop);
      bus.overflow <= bus.wr_en & bus.full;
      ram_cnt      <= ram_cnt + CW'(wr_acc) - CW'(bus.rd_en);
      inflight     <= bus.rd_en;
      buf_cnt      <= buf_cnt + 2'(inflight) - 2'(pop);
      // a full buffer never has a read in flight, so a pop either shifts b1 or takes the returning word
      if (pop) b0 <= buf_cnt[1] ? b1 : bus.rd_data;
      else if (inflight) begin
        if (buf_cnt == 2'd0) b0 <= bus.rd_data;
        else b1 <= bus.rd_data;
      end
    end
  end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: two instances (SIZE 8 and 6) driven in lockstep against a queue-based model
module tb_fifo_stream_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_en = 1'b0;
  logic dout_ready = 1'b0;
  logic [7:0] wdata = '0;
  always #5 clk = ~clk;
  fifo_stream_reader_if #(.SIZE(8), .DATA_WIDTH(8)) f0 ();
  fifo_stream_reader_if #(.SIZE(6), .DATA_WIDTH(8)) f1 ();
  fifo_stream_reader #(.SIZE(8), .DATA_WIDTH(8)) d0 (.clk(clk), .rst(rst), .bus(f0));
  fifo_stream_reader #(.SIZE(6), .DATA_WIDTH(8)) d1 (.clk(clk), .rst(rst), .bus(f1));
  assign f0.wr_en = wr_en;
  assign f1.wr_en = wr_en;
  assign f0.dout_ready = dout_ready;
  assign f1.dout_ready = dout_ready;
  logic [7:0] ram0 [8];
  logic [7:0] ram1 [8];
  always_ff @(posedge clk) begin
    if (f0.wr_en) ram0[f0.wr_addr] <= wdata;
    if (f0.rd_en) f0.rd_data <= ram0[f0.rd_addr];
    if (f1.wr_en) ram1[f1.wr_addr] <= wdata;
    if (f1.rd_en) f1.rd_data <= ram1[f1.rd_addr];
  end
  logic [31:0] o_cnt [2], o_wa [2], o_ra [2];
  logic [7:0]  o_dout [2];
  logic        o_v [2], o_full [2], o_empty [2], o_ovf [2];
  assign o_cnt[0] = 32'(f0.count);    assign o_cnt[1] = 32'(f1.count);
  assign o_wa[0]  = 32'(f0.wr_addr);  assign o_wa[1]  = 32'(f1.wr_addr);
  assign o_ra[0]  = 32'(f0.rd_addr);  assign o_ra[1]  = 32'(f1.rd_addr);
  assign o_dout[0] = f0.dout;         assign o_dout[1] = f1.dout;
  assign o_v[0] = f0.dout_valid;      assign o_v[1] = f1.dout_valid;
  assign o_full[0] = f0.full;         assign o_full[1] = f1.full;
  assign o_empty[0] = f0.empty;       assign o_empty[1] = f1.empty;
  assign o_ovf[0] = f0.overflow;      assign o_ovf[1] = f1.overflow;
  // model: accepted words with the edge number they were written on; visible two edges later
  int sz [2] = '{8, 6};
  logic [7:0] md [2][64];
  int mt [2][64];
  int head [2], tail [2];
  logic movf [2];
  int cyc = 0;
  int maxc = 0;
  int n_chk = 0, n_fail = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    wr_en = 1'b0;
    dout_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_count%0d", k), o_cnt[k], 0);
      check($sformatf("rst_full%0d", k), o_full[k], 0);
      check($sformatf("rst_empty%0d", k), o_empty[k], 1);
      check($sformatf("rst_dout%0d", k), o_dout[k], 0);
      check($sformatf("rst_valid%0d", k), o_v[k], 0);
      check($sformatf("rst_ovf%0d", k), o_ovf[k], 0);
      check($sformatf("rst_wa%0d", k), o_wa[k], 0);
      check($sformatf("rst_ra%0d", k), o_ra[k], 0);
      head[k] = 0;
      tail[k] = 0;
      movf[k] = 1'b0;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic step(input logic we, input logic [7:0] d, input logic rdy);
    int n;
    logic v;
    logic acc [2], pp [2], ovn [2];
    @(negedge clk);
    wr_en = we;
    wdata = d;
    dout_ready = rdy;
    #1;
    if (o_cnt[0] > maxc) maxc = o_cnt[0];
    for (int k = 0; k < 2; k++) begin
      n = tail[k] - head[k];
      v = n > 0 && cyc - mt[k][head[k] % 64] >= 2;
      check($sformatf("count%0d", k), o_cnt[k], n);
      check($sformatf("full%0d", k), o_full[k], n == sz[k]);
      check($sformatf("empty%0d", k), o_empty[k], n == 0);
      check($sformatf("valid%0d", k), o_v[k], v);
      check($sformatf("ovf%0d", k), o_ovf[k], movf[k]);
      check($sformatf("wr_addr%0d", k), o_wa[k], tail[k] % sz[k]);
      if (v) check($sformatf("dout%0d", k), o_dout[k], md[k][head[k] % 64]);
      acc[k] = we && n < sz[k];
      pp[k]  = v && rdy;
      ovn[k] = we && n == sz[k];
    end
    @(posedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (acc[k]) begin
        md[k][tail[k] % 64] = d;
        mt[k][tail[k] % 64] = cyc;
        tail[k]++;
      end
      if (pp[k]) head[k]++;
      movf[k] = ovn[k];
    end
  endtask
  initial begin
    do_reset();
    step(1'b1, 8'hA5, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1);
    do_reset();
    for (int i = 0; i < 9; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 8'h00, 1'b1);
    do_reset();
    maxc = 0;
    for (int i = 0; i < 20; i++) step(1'b1, 8'(i), 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
    check("max_count", 32'(maxc <= 3), 1);
    do_reset();
    for (int i = 0; i < 30; i++) step(1'b1, 8'(i), i % 3 != 2);
    for (int i = 0; i < 24; i++) step(1'b0, 8'h00, i % 3 != 2);
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
    #1;
    check("pre_rst_full", o_full[0], 1);
    check("pre_rst_valid", o_v[0], 1);
    do_reset();
    step(1'b1, 8'h3C, 1'b0);
    step(1'b1, 8'h3D, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1);
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h77, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 8'h00, 1'b1);
    do_reset();
    step(1'b1, 8'h01, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h02, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
    for (int s = 0; s < 4; s++)
      for (int i = 0; i < 150; i++)
        step($urandom_range(3) != 0, 8'($urandom), $urandom_range(3) <= s);
    for (int i = 0; i < 12; i++) step(1'b0, 8'h00, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
